// File: rtl/spi_slave_pkg.sv
// Shared SPI slave constants and FSM state encoding.
package spi_slave_pkg;
   localparam int SPI_BYTE_W      = 8;
   localparam int SPI_MIN_CLK_DIV = 8;
   localparam int SPI_CNT_W       = 4;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_SHIFT = 2'd2;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus transmit/receive handshake of the SPI slave.
interface spi_slave_if;
   import spi_slave_pkg::*;

   logic                  sclk;
   logic                  cs;
   logic                  mosi;
   logic                  miso;
   logic                  miso_oe;
   logic [SPI_BYTE_W-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [SPI_BYTE_W-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;
   logic                  tx_underrun;
   logic                  frame_err;
   logic                  irq;

   modport slave (
      input  sclk, cs, mosi, tx_data, tx_valid,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err, irq
   );

   modport master (
      output sclk, cs, mosi, tx_data, tx_valid,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err, irq
   );
endinterface

// File: rtl/spi_slave_sync.sv
// Flop-chain synchronizer for one asynchronous input, with selectable reset level.
module spi_slave_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= {SYNC_STAGES{RST_VAL}};
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with a one-entry transmit holding register.
// Optional feature: define SPI_SLAVE_IRQ_EN for a registered interrupt pulse on irq.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'h00
) (
   input logic         clk,
   input logic         reset,
   spi_slave_if.slave  bus
);
   logic sclk_s, cs_s, mosi_s;
   logic sclk_prev_q, cs_prev_q;
   logic sclk_rise, sclk_fall, cs_fall;

   state_t state_q, state_d;
   logic   load_en, sample_en, shift_en, end_frame;

   logic [SPI_BYTE_W-1:0] shift_q, shift_d;
   logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
   logic [SPI_BYTE_W-1:0] hold_q, hold_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic [SPI_BYTE_W-1:0] loaded;
   logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic hold_full_q, hold_full_d;
   logic reload_pend_q, reload_pend_d;
   logic miso_q, miso_d, miso_oe_q, miso_oe_d;
   logic rx_valid_q, rx_valid_d, busy_q, busy_d;
   logic underrun_q, underrun_d, frame_err_q, frame_err_d;
   logic wr_en;

   spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset(reset), .d_i(bus.sclk), .q_o(sclk_s));
   spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .d_i(bus.cs), .q_o(cs_s));
   spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .d_i(bus.mosi), .q_o(mosi_s));

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         state_q     <= ST_IDLE;
      end else begin
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         state_q     <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cs_fall) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: if (cs_s) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // A deselect seen in the same cycle as an sclk edge wins, so a final fall never reloads.
   always_comb begin
      load_en   = 1'b0;
      sample_en = 1'b0;
      shift_en  = 1'b0;
      end_frame = 1'b0;
      case (state_q)
         ST_LOAD: load_en = 1'b1;
         ST_SHIFT: begin
            if (cs_s) begin
               end_frame = 1'b1;
            end else begin
               sample_en = sclk_rise;
               load_en   = sclk_fall & reload_pend_q;
               shift_en  = sclk_fall & ~reload_pend_q;
            end
         end
         default: ;
      endcase
   end

   assign wr_en  = bus.tx_valid & ~hold_full_q;
   assign loaded = hold_full_q ? hold_q : DEFAULT_TX;

   always_comb begin
      shift_d       = shift_q;
      rx_shift_d    = rx_shift_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      rx_data_d     = rx_data_q;
      bit_cnt_d     = bit_cnt_q;
      reload_pend_d = reload_pend_q;
      miso_d        = miso_q;
      miso_oe_d     = miso_oe_q;
      rx_valid_d    = 1'b0;
      underrun_d    = 1'b0;
      frame_err_d   = 1'b0;
      busy_d        = ~cs_s;

      if (load_en) begin
         shift_d       = loaded;
         miso_d        = loaded[SPI_BYTE_W-1];
         miso_oe_d     = 1'b1;
         bit_cnt_d     = '0;
         reload_pend_d = 1'b0;
         underrun_d    = ~hold_full_q;
      end

      if (shift_en) begin
         shift_d = {shift_q[SPI_BYTE_W-2:0], 1'b0};
         miso_d  = shift_q[SPI_BYTE_W-2];
      end

      if (sample_en) begin
         rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
         if (bit_cnt_q == SPI_CNT_W'(SPI_BYTE_W - 1)) begin
            rx_data_d     = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
            rx_valid_d    = 1'b1;
            bit_cnt_d     = '0;
            reload_pend_d = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
         end
      end

      if (end_frame) begin
         miso_d        = 1'b0;
         miso_oe_d     = 1'b0;
         bit_cnt_d     = '0;
         reload_pend_d = 1'b0;
         rx_shift_d    = '0;
         frame_err_d   = (bit_cnt_q != '0);
      end

      // An empty-hold LOAD coinciding with a write underruns, yet keeps the byte for later.
      if (load_en && hold_full_q) begin
         hold_full_d = 1'b0;
      end else if (wr_en) begin
         hold_d      = bus.tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q       <= '0;
         rx_shift_q    <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         rx_data_q     <= '0;
         bit_cnt_q     <= '0;
         reload_pend_q <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         rx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         underrun_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         shift_q       <= shift_d;
         rx_shift_q    <= rx_shift_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         rx_data_q     <= rx_data_d;
         bit_cnt_q     <= bit_cnt_d;
         reload_pend_q <= reload_pend_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         rx_valid_q    <= rx_valid_d;
         busy_q        <= busy_d;
         underrun_q    <= underrun_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign bus.miso        = miso_q;
   assign bus.miso_oe     = miso_oe_q;
   assign bus.tx_ready    = ~hold_full_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.busy        = busy_q;
   assign bus.tx_underrun = underrun_q;
   assign bus.frame_err   = frame_err_q;

`ifdef SPI_SLAVE_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= rx_valid_q | frame_err_q | underrun_q;
   end

   assign bus.irq = irq_q;
`else
   assign bus.irq = 1'b0;
`endif
endmodule
